// File: rtl/mult8_host_pkg.sv
// mult8_host_pkg: types and constants shared by the mult8 host driver
// and any bench that drives or observes the multiplier tile pins.
//   host_state_t : driver sequencer states
//   UIO_*        : bit positions on the tile's uio_in / uio_out pins
//   max3()       : helper used to size the shared driver counter
package mult8_host_pkg;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_LOAD_A,
    S_GAP_A,
    S_LOAD_B,
    S_GAP_B,
    S_START,
    S_GAP_S,
    S_WAIT_DONE,
    S_RD_LO,
    S_RD_HI,
    S_RESP
  } host_state_t;

  localparam int UIO_LOAD_A  = 0;
  localparam int UIO_LOAD_B  = 1;
  localparam int UIO_START   = 2;
  localparam int UIO_OUT_SEL = 3;
  localparam int UIO_DONE    = 7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mult8_host_driver.sv
// mult8_host_driver: host-side sequencer for the 8x8 shift-add multiplier
// tile. Takes an (A, B) request, pulses load_A / load_B / start on the
// tile pins, polls done (with timeout), reads the product back a byte at
// a time through out_sel, and returns {hi, lo} on the response channel.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           request handshake, operands req_a, req_b
//   rsp_valid/rsp_ready           response handshake
//   rsp_product, rsp_timeout      16-bit product / done-never-seen flag
//   tile_ena                      tile select (1 from first clock after reset)
//   tile_ui_in                    operand bus to the tile
//   tile_uio_in                   control pins (load_A, load_B, start, out_sel)
//   tile_uo_out                   tile result byte
//   tile_uio_out                  tile status (bit 7 = done)
//
// Every output is a register. Outputs are computed from the next state,
// so each pin changes on the same edge the FSM enters the state it
// belongs to.
module mult8_host_driver
  import mult8_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50,
  parameter int READ_SETTLE    = 1,
  parameter int INIT_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_product,
  output logic        rsp_timeout,
  output logic        tile_ena,
  output logic [7:0]  tile_ui_in,
  output logic [7:0]  tile_uio_in,
  input  logic [7:0]  tile_uo_out,
  input  logic [7:0]  tile_uio_out
);

  localparam int CNT_MAX = max3(TIMEOUT_CYCLES, READ_SETTLE, INIT_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] C_INIT    = CW'(INIT_CYCLES);
  localparam logic [CW-1:0] C_RS_LAST = CW'(READ_SETTLE - 1);
  localparam logic [CW-1:0] C_ONE     = CW'(1);

  host_state_t r_state, w_nxt_state;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic [7:0]  r_a, r_b, r_lo;
  logic        w_accept, w_cap_lo, w_cap_hi, w_to_hit;
  logic [7:0]  w_nxt_uio;

  // Only the done bit of the status pins is meaningful.
  logic w_unused;
  assign w_unused = ^tile_uio_out[6:0];

  // Output registers
  logic        r_req_ready, r_rsp_valid, r_rsp_timeout, r_ena;
  logic [15:0] r_rsp_product;
  logic [7:0]  r_ui, r_uio;

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_product = r_rsp_product;
  assign rsp_timeout = r_rsp_timeout;
  assign tile_ena    = r_ena;
  assign tile_ui_in  = r_ui;
  assign tile_uio_in = r_uio;

  // Next state. r_cnt is shared: init length, done-wait timeout, and the
  // out_sel settle time in both read states.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_accept    = 1'b0;
    w_cap_lo    = 1'b0;
    w_cap_hi    = 1'b0;
    w_to_hit    = 1'b0;
    case (r_state)
      S_INIT: begin
        if (r_cnt == C_INIT) begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + C_ONE;
        end
      end
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_accept    = 1'b1;
          w_nxt_state = S_LOAD_A;
        end
      end
      S_LOAD_A: w_nxt_state = S_GAP_A;
      S_GAP_A:  w_nxt_state = S_LOAD_B;
      S_LOAD_B: w_nxt_state = S_GAP_B;
      S_GAP_B:  w_nxt_state = S_START;
      S_START:  w_nxt_state = S_GAP_S;
      S_GAP_S: begin
        w_nxt_state = S_WAIT_DONE;
        w_nxt_cnt   = '0;
      end
      S_WAIT_DONE: begin
        // Done wins over timeout in the same cycle.
        if (tile_uio_out[UIO_DONE]) begin
          w_nxt_state = S_RD_LO;
          w_nxt_cnt   = '0;
        end else if (r_cnt == C_TIMEOUT) begin
          w_to_hit    = 1'b1;
          w_nxt_state = S_RESP;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + C_ONE;
        end
      end
      S_RD_LO: begin
        if (r_cnt == C_RS_LAST) begin
          w_cap_lo    = 1'b1;
          w_nxt_state = S_RD_HI;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + C_ONE;
        end
      end
      S_RD_HI: begin
        if (r_cnt == C_RS_LAST) begin
          w_cap_hi    = 1'b1;
          w_nxt_state = S_RESP;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + C_ONE;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_INIT;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // Control pin image for the state being entered.
  always_comb begin
    w_nxt_uio = '0;
    case (w_nxt_state)
      S_LOAD_A: w_nxt_uio[UIO_LOAD_A]  = 1'b1;
      S_LOAD_B: w_nxt_uio[UIO_LOAD_B]  = 1'b1;
      S_START:  w_nxt_uio[UIO_START]   = 1'b1;
      S_RD_HI:  w_nxt_uio[UIO_OUT_SEL] = 1'b1;
      default:  w_nxt_uio = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_INIT;
      r_cnt         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_lo          <= '0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_product <= '0;
      r_rsp_timeout <= 1'b0;
      r_ena         <= 1'b0;
      r_ui          <= '0;
      r_uio         <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_ena       <= 1'b1;
      r_req_ready <= (w_nxt_state == S_IDLE);
      r_rsp_valid <= (w_nxt_state == S_RESP);
      r_uio       <= w_nxt_uio;

      if (w_accept) begin
        r_a <= req_a;
        r_b <= req_b;
      end

      // LOAD_A is only entered on the accept edge, so it takes the
      // operand straight from the request bus.
      case (w_nxt_state)
        S_LOAD_A:                           r_ui <= req_a;
        S_GAP_A:                            r_ui <= r_a;
        S_LOAD_B, S_GAP_B, S_START, S_GAP_S: r_ui <= r_b;
        default:                            r_ui <= r_ui;
      endcase

      if (w_cap_lo) r_lo <= tile_uo_out;
      if (w_cap_hi) begin
        r_rsp_product <= {tile_uo_out, r_lo};
        r_rsp_timeout <= 1'b0;
      end else if (w_to_hit) begin
        r_rsp_product <= '0;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult8_host_driver.sv
// tb_mult8_host_driver: randomized self-checking bench for
// mult8_host_driver. A behavioural tile model answers the pin protocol
// with a per-request programmable done delay (or never); the expected
// product, timeout flag and latency are derived from the request alone.
module tb_mult8_host_driver;

  localparam int TO   = 50;
  localparam int RS   = 1;
  localparam int INIT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_a = '0, req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_product;
  logic        rsp_timeout;
  logic        tile_ena;
  logic [7:0]  tile_ui_in, tile_uio_in, tile_uo_out, tile_uio_out;

  int n_chk = 0;
  int n_err = 0;

  mult8_host_driver #(
    .TIMEOUT_CYCLES(TO), .READ_SETTLE(RS), .INIT_CYCLES(INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_product(rsp_product), .rsp_timeout(rsp_timeout),
    .tile_ena(tile_ena), .tile_ui_in(tile_ui_in), .tile_uio_in(tile_uio_in),
    .tile_uo_out(tile_uo_out), .tile_uio_out(tile_uio_out)
  );

  always #5 clk = ~clk;

  // Tile model: latches operands on load pulses; done rises done_dly
  // cycles into WAIT_DONE (negative = never); out_sel picks the byte.
  int         done_dly = 0;
  logic [7:0] t_a = '0, t_b = '0;
  logic       t_busy = 1'b0;
  int         t_cnt = 0;
  logic [15:0] t_prod;
  logic       t_done;

  always @(posedge clk) begin
    if (tile_uio_in[0]) t_a <= tile_ui_in;
    if (tile_uio_in[1]) t_b <= tile_ui_in;
    if (tile_uio_in[2]) begin
      t_busy <= 1'b1;
      t_cnt  <= 0;
    end else if (t_busy) begin
      t_cnt <= t_cnt + 1;
    end
  end

  assign t_prod       = 16'(t_a) * 16'(t_b);
  assign t_done       = t_busy && (done_dly >= 0) && (t_cnt >= done_dly + 1);
  assign tile_uio_out = {t_done, 7'h55};
  assign tile_uo_out  = tile_uio_in[3] ? t_prod[15:8] : t_prod[7:0];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    int n;
    logic seen;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'({req_ready, rsp_valid, rsp_product, rsp_timeout,
                         tile_ena, tile_ui_in, tile_uio_in}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ena_1clk", 64'(tile_ena), 64'd1);
    n = 1; seen = 1'b0;
    while (!req_ready && n < 20) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("init_len", 64'(n), 64'(INIT + 1));
    chk("init_no_rsp", 64'(seen), 64'd0);
  endtask

  task automatic run_req(input logic [7:0] a, input logic [7:0] b,
                         input int d, input int hold);
    int n, rel, p0, p1, p2, npulse, nsel, nhi, nrdy, exp_lat;
    logic [15:0] exp_p;
    logic        exp_to;
    logic [16:0] snap;
    if (d < 0 || d > TO) begin
      exp_to = 1'b1; exp_p = 16'h0; exp_lat = 8 + TO;
    end else begin
      exp_to = 1'b0; exp_p = 16'(a) * 16'(b); exp_lat = 8 + 2 * RS + d;
    end
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_ready", 64'(req_ready), 64'd1);
    done_dly = d; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Junk request held valid while busy must be ignored.
    req_a = 8'($urandom); req_b = 8'($urandom); req_valid = 1'b1;
    rel = 1; p0 = 0; p1 = 0; p2 = 0; npulse = 0; nsel = 0; nhi = 0; nrdy = 0;
    while (!rsp_valid && rel < 200) begin
      if (tile_uio_in[0]) begin p0 = rel; npulse++; end
      if (tile_uio_in[1]) begin p1 = rel; npulse++; end
      if (tile_uio_in[2]) begin p2 = rel; npulse++; end
      if (tile_uio_in[3]) nsel++;
      if (tile_uio_in[7:4] != 4'h0) nhi++;
      if (req_ready) nrdy++;
      @(negedge clk);
      rel++;
    end
    req_valid = 1'b0;
    chk("pos_loadA", 64'(p0), 64'd1);
    chk("pos_loadB", 64'(p1), 64'd3);
    chk("pos_start", 64'(p2), 64'd5);
    chk("pulse_cnt", 64'(npulse), 64'd3);
    chk("outsel_cnt", 64'(nsel), 64'(exp_to ? 0 : RS));
    chk("uio_hi_zero", 64'(nhi), 64'd0);
    chk("busy_ready", 64'(nrdy), 64'd0);
    chk("latency", 64'(rel), 64'(exp_lat));
    chk("product", 64'(rsp_product), 64'(exp_p));
    chk("timeout", 64'(rsp_timeout), 64'(exp_to));
    chk("resp_pins", 64'(tile_uio_in), 64'd0);
    snap = {rsp_timeout, rsp_product};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold", 64'({rsp_valid, req_ready, rsp_timeout, rsp_product}),
          64'({1'b1, 1'b0, snap}));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    chk("rdy_after", 64'(req_ready), 64'd1);
  endtask

  initial begin
    do_reset();

    run_req(8'hAA, 8'h0F, 0, 0);
    run_req(8'h7F, 8'h80, 0, 0);
    run_req(8'hFF, 8'hFF, 0, 0);
    run_req(8'h12, 8'h34, -1, 0);
    run_req(8'h33, 8'h44, 3, 0);
    run_req(8'h01, 8'hFF, 2, 5);
    run_req(8'hFF, 8'hFF, 0, 0);
    run_req(8'h9C, 8'h27, TO, 1);
    run_req(8'h5A, 8'hC3, TO + 1, 0);
    for (int k = 0; k < 12; k++)
      run_req(8'($urandom), 8'($urandom), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)));

    // Reset in the middle of WAIT_DONE.
    begin
      int n;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      done_dly = -1; req_a = 8'h3C; req_b = 8'h5A; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("pre_rst_ui", 64'(tile_ui_in), 64'h5A);
      #1 rst_n = 1'b0;
      #1 chk("rst_async", 64'({req_ready, rsp_valid, rsp_product, rsp_timeout,
                               tile_ena, tile_ui_in, tile_uio_in}), 64'd0);
    end
    do_reset();
    run_req(8'hFE, 8'h03, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
